// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - operation encodings carried on the op bus
//   - FSM state encoding
//   - default operand width
//   - HI/LO write-enable pattern for a full result write
package mdu_iter_pkg;

  localparam int MDU_DATA_W = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement of a width-parameterised bus.
// Ports:
//   din  - value to (optionally) negate
//   neg  - 1: dout = -din, 0: dout = din
//   dout - result, same width as din
module mdu_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  // Operating on unsigned bits makes -(2^(W-1)) map to itself, which is
  // exactly the magnitude 2^(W-1) when read back as unsigned.
  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU), one iteration per
// clock over DATA_W cycles, followed by a sign-fix cycle and a one-cycle
// completion strobe that writes {HI,LO}.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request an operation (sampled only while idle)
//   op       - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    - multiplicand / dividend
//   src_b    - multiplier / divisor
//   flush    - cancel any in-flight operation, no write
//   busy     - operation in flight
//   done     - one-cycle completion strobe
//   hilo_we  - {HI,LO} write enables, 2'b11 only in the done cycle
//   hilo_out - {HI,LO}; holds the last completed result
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            hilo_we,
  output logic [2*DATA_W-1:0]   hilo_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mdu_state_t          state;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic                sign_a;
  logic                sign_b;
  logic                b_zero;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;

  // Operand capture: magnitudes for signed ops, pass-through otherwise.
  logic              in_signed;
  logic              in_sign_a;
  logic              in_sign_b;
  logic              in_is_mul;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;

  assign in_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign in_sign_a = in_signed & src_a[DATA_W-1];
  assign in_sign_b = in_signed & src_b[DATA_W-1];
  assign in_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);

  mdu_negate #(.W(DATA_W)) u_neg_a (.din(src_a), .neg(in_sign_a), .dout(abs_a));
  mdu_negate #(.W(DATA_W)) u_neg_b (.din(src_b), .neg(in_sign_b), .dout(abs_b));

  logic is_mul;
  assign is_mul = (op_q == MDU_MULT) || (op_q == MDU_MULTU);

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  // Add the multiplicand into the upper half when the multiplier LSB is
  // set, then shift the whole thing right, keeping the carry.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] acc_mul_next;

  assign mul_sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign acc_mul_next = {mul_sum, acc[DATA_W-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient}.
  // The divisor is subtracted from the remainder with the next dividend
  // bit shifted in; a clear MSB on the difference means it fits.
  // With a zero divisor every step "fits", which naturally leaves an
  // all-ones quotient and the dividend magnitude as the remainder.
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_fit;
  logic [2*DATA_W-1:0] acc_div_next;

  assign div_shift    = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_diff     = div_shift - {1'b0, mag_b};
  assign div_fit      = ~div_diff[DATA_W];
  assign acc_div_next = {(div_fit ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                         acc[DATA_W-2:0], div_fit};

  // Sign correction. Unsigned ops latch both sign flags as 0, so these
  // conditions collapse to pass-through for them. Negating the remainder
  // by the dividend sign also restores the raw dividend on divide-by-zero.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  mdu_negate #(.W(2*DATA_W)) u_neg_prod (
    .din(acc), .neg(sign_a ^ sign_b), .dout(prod_fix)
  );
  mdu_negate #(.W(DATA_W)) u_neg_quo (
    .din(acc[DATA_W-1:0]), .neg((sign_a ^ sign_b) & ~b_zero), .dout(quo_fix)
  );
  mdu_negate #(.W(DATA_W)) u_neg_rem (
    .din(acc[2*DATA_W-1:DATA_W]), .neg(sign_a), .dout(rem_fix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= 2'b00;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hilo_we  <= 2'b00;
      hilo_out <= '0;
    end else if (flush) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hilo_we <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          done    <= 1'b0;
          hilo_we <= 2'b00;
          if (start) begin
            state  <= ST_CALC;
            busy   <= 1'b1;
            op_q   <= op;
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            b_zero <= (src_b == '0);
            cnt    <= '0;
            acc    <= {{DATA_W{1'b0}}, (in_is_mul ? abs_b : abs_a)};
          end
        end
        ST_CALC: begin
          acc <= is_mul ? acc_mul_next : acc_div_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          hilo_out <= is_mul ? prod_fix : {rem_fix, quo_fix};
          state    <= ST_DONE;
          done     <= 1'b1;
          hilo_we  <= HILO_WE_BOTH;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          hilo_we <= 2'b00;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          hilo_we <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [1:0]  hilo_we;
  logic [63:0] hilo_out;

  int n_cmp;
  int n_bad;
  int done_pulses;
  int we_pulses;

  mdu_iter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .hilo_we(hilo_we), .hilo_out(hilo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_pulses <= done_pulses + 1;
    if (hilo_we != 2'b00) we_pulses <= we_pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for done (bounded), check strobe and latency.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_res"}, hilo_out, exp);
    check({tag, "_we"}, {62'd0, hilo_we}, 64'd3);
    @(posedge clk); #1;
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    int d0;
    int w0;
    n_cmp = 0; n_bad = 0; done_pulses = 0; we_pulses = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_we", {62'd0, hilo_we}, 64'd0);
    check("rst_hilo", hilo_out, 64'd0);
    rst_n = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    run_op("divu_by0", 2'b11, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF);
    run_op("div_by0", 2'b10, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF);
    run_op("div_min_by0", 2'b10, 32'h8000_0000, 32'd0, 64'h8000_0000_FFFF_FFFF);
    run_op("div_min_dm1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // Flush at CALC cycle 10.
    prev = hilo_out;
    d0 = done_pulses; w0 = we_pulses;
    @(negedge clk);
    op = 2'b01; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hilo", hilo_out, prev);
    check("flush_nodone", 64'(done_pulses - d0), 64'd0);
    check("flush_nowe", 64'(we_pulses - w0), 64'd0);
    run_op("post_flush", 2'b01, 32'd3, 32'd4, 64'd12);

    // start held high through the whole operation: exactly one done.
    d0 = done_pulses;
    @(negedge clk);
    op = 2'b01; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    check("hold_done", {63'd0, done}, 64'd1);
    check("hold_res", hilo_out, 64'd42);
    @(negedge clk);
    start = 1'b0;
    // Back-to-back: issue in the idle cycle right after DONE.
    @(posedge clk); #1;
    check("hold_pulses", 64'(done_pulses - d0), 64'd1);
    op = 2'b11; src_a = 32'd50; src_b = 32'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    repeat (33) @(posedge clk);
    #1;
    check("b2b_done", {63'd0, done}, 64'd1);
    check("b2b_res", hilo_out, 64'h0000_0002_0000_0006);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_we", {62'd0, hilo_we}, 64'd0);
    check("arst_hilo", hilo_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b00, 32'd9, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
